// File: rtl/grad_conv_seq.sv
// Sequential window/kernel correlator: one product pair per cycle into two accumulators, then saturated magnitudes.
// Optional macro GRAD_CONV_MAG_MAX_EN: in dual modes mag = max(mod1, mod2) instead of the saturated sum.
module grad_conv_seq #(
    parameter int DIM    = 5,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 seletor,
    input  logic [DIM*DIM*DATA_W-1:0]  matriz_a,
    input  logic [DIM*DIM*DATA_W-1:0]  matriz_b,
    output logic [3*DATA_W-1:0]        result,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 dbg_state
);

    localparam int N     = DIM*DIM;
    localparam int IDX_W = $clog2(N);
    localparam int RC_W  = $clog2(DIM);
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SUM  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [N*DATA_W-1:0]         r_a;
    logic [N*DATA_W-1:0]         r_b;
    logic [1:0]                  r_sel;
    logic signed [ACC_W-1:0]     r_acc1;
    logic signed [ACC_W-1:0]     r_acc2;
    logic [IDX_W-1:0]            r_k;
    logic [RC_W-1:0]             r_r;
    logic [RC_W-1:0]             r_c;
    logic [3*DATA_W-1:0]         r_result;
    logic                        r_done;

    logic                        w_last;
    logic [IDX_W-1:0]            w_idx_tr;
    logic [IDX_W-1:0]            w_idx_rot;
    logic [IDX_W-1:0]            w_k2_idx;
    logic signed [DATA_W-1:0]    w_a_el;
    logic signed [DATA_W-1:0]    w_b_el;
    logic signed [DATA_W-1:0]    w_k2_el;
    logic signed [2*DATA_W-1:0]  w_p1;
    logic signed [2*DATA_W-1:0]  w_p2;
    logic [ACC_W-1:0]            w_abs1;
    logic [ACC_W-1:0]            w_abs2;
    logic [DATA_W-1:0]           w_sat1;
    logic [DATA_W-1:0]           w_mod1;
    logic [DATA_W-1:0]           w_mod2;
    logic [DATA_W-1:0]           w_mag_dual;
    logic [DATA_W-1:0]           w_mag;

    // Handshake: start is a level held for the whole operation; done stays high while start
    // remains high and drops one edge after start falls. Dropping start before DONE aborts.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    assign w_last = (r_k == IDX_W'(N-1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN:  begin
                if (!start)      w_next = S_IDLE;
                else if (w_last) w_next = S_SUM;
            end
            S_SUM:  w_next = start ? S_DONE : S_IDLE;
            S_DONE: if (!start) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Second kernel element for (r,c): transpose reads b(c,r), rotation reads b(DIM-1-c, r).
    assign w_idx_tr  = IDX_W'(r_c) * IDX_W'(DIM) + IDX_W'(r_r);
    assign w_idx_rot = (IDX_W'(DIM-1) - IDX_W'(r_c)) * IDX_W'(DIM) + IDX_W'(r_r);
    assign w_k2_idx  = r_sel[1] ? (r_sel[0] ? w_idx_rot : w_idx_tr) : r_k;

    always_comb begin
        w_a_el  = '0;
        w_b_el  = '0;
        w_k2_el = '0;
        for (int i = 0; i < N; i++) begin
            if (r_k == IDX_W'(i)) begin
                w_a_el = r_a[i*DATA_W +: DATA_W];
                w_b_el = r_b[i*DATA_W +: DATA_W];
            end
            if (w_k2_idx == IDX_W'(i)) begin
                w_k2_el = r_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_p1 = w_a_el * w_b_el;
    assign w_p2 = w_a_el * w_k2_el;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_acc1   <= '0;
            r_acc2   <= '0;
            r_k      <= '0;
            r_r      <= '0;
            r_c      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE) && start;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a    <= matriz_a;
                        r_b    <= matriz_b;
                        r_sel  <= seletor;
                        r_acc1 <= '0;
                        r_acc2 <= '0;
                        r_k    <= '0;
                        r_r    <= '0;
                        r_c    <= '0;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        r_acc1 <= r_acc1 + {{(ACC_W-2*DATA_W){w_p1[2*DATA_W-1]}}, w_p1};
                        r_acc2 <= r_acc2 + {{(ACC_W-2*DATA_W){w_p2[2*DATA_W-1]}}, w_p2};
                        r_k    <= r_k + IDX_W'(1);
                        if (r_c == RC_W'(DIM-1)) begin
                            r_c <= '0;
                            r_r <= r_r + RC_W'(1);
                        end else begin
                            r_c <= r_c + RC_W'(1);
                        end
                    end
                end
                S_SUM: begin
                    if (start) r_result <= {w_mag, w_mod2, w_mod1};
                end
                default: ;
            endcase
        end
    end

    // Saturation happens only here; the accumulators are wide enough never to wrap.
    assign w_abs1 = r_acc1[ACC_W-1] ? -r_acc1 : r_acc1;
    assign w_abs2 = r_acc2[ACC_W-1] ? -r_acc2 : r_acc2;
    assign w_sat1 = (w_abs1 > SAT_MAX) ? {DATA_W{1'b1}} : w_abs1[DATA_W-1:0];
    assign w_mod2 = (w_abs2 > SAT_MAX) ? {DATA_W{1'b1}} : w_abs2[DATA_W-1:0];
    assign w_mod1 = (!r_sel[1] && r_acc1[ACC_W-1]) ? '0 : w_sat1;

`ifdef GRAD_CONV_MAG_MAX_EN
    assign w_mag_dual = (w_mod1 > w_mod2) ? w_mod1 : w_mod2;
`else
    logic [DATA_W:0] w_sum;
    assign w_sum      = {1'b0, w_mod1} + {1'b0, w_mod2};
    assign w_mag_dual = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`endif

    assign w_mag = r_sel[1] ? w_mag_dual : w_mod1;

    assign result    = r_result;
    assign done      = r_done;
    assign busy      = (r_state == S_RUN) || (r_state == S_SUM);
    assign dbg_state = r_state;

endmodule
